// File: rtl/countdown_timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the MM:SS countdown timer.
//   state_t      : controller states (IDLE, RUN, PAUSE, DONE)
//   BCD_W        : width of one BCD digit
//   BCD_MAX      : largest legal BCD digit
//   SEC_TENS_MAX : largest tens-of-seconds digit (59 -> 5)
//   HALF_TENS    : tens-of-seconds digit loaded for a half-minute setting
//   bcd_clamp()  : saturates a 4-bit value to a legal BCD digit
// ---------------------------------------------------------------------------
package timer_pkg;

   localparam int BCD_W        = 4;
   localparam int BCD_MAX      = 9;
   localparam int SEC_TENS_MAX = 5;
   localparam int HALF_TENS    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
      return (d > BCD_W'(BCD_MAX)) ? BCD_W'(BCD_MAX) : d;
   endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_if
// Setting, control-pulse and display/status bundle of the countdown timer.
//   set_hi/set_lo/set_half : minute setting from the setup block
//   start_stop/cancel      : one-cycle pulses from the debouncers
//   m_hi/m_lo/s_hi/s_lo    : displayed BCD digits MM:SS
//   running/alarm/done     : status (done is a one-cycle pulse)
// master = the side driving setting/controls, slave = the timer.
// ---------------------------------------------------------------------------
interface countdown_timer_if;
   import timer_pkg::*;

   logic [BCD_W-1:0] set_hi;
   logic [BCD_W-1:0] set_lo;
   logic             set_half;
   logic             start_stop;
   logic             cancel;
   logic [BCD_W-1:0] m_hi;
   logic [BCD_W-1:0] m_lo;
   logic [BCD_W-1:0] s_hi;
   logic [BCD_W-1:0] s_lo;
   logic             running;
   logic             alarm;
   logic             done;

   modport master (
      output set_hi, set_lo, set_half, start_stop, cancel,
      input  m_hi, m_lo, s_hi, s_lo, running, alarm, done
   );

   modport slave (
      input  set_hi, set_lo, set_half, start_stop, cancel,
      output m_hi, m_lo, s_hi, s_lo, running, alarm, done
   );

endinterface

// File: rtl/countdown_timer_bcd_dec.sv
// ---------------------------------------------------------------------------
// timer_bcd_dec
// Combinational one-second decrement of an MM:SS BCD value.
//   en                     : apply the decrement (ignored at 00:00)
//   m_hi_i..s_lo_i         : current digits
//   m_hi_o..s_lo_o         : next digits
//   is_one / is_zero       : current value is 00:01 / 00:00
// ---------------------------------------------------------------------------
module timer_bcd_dec
   import timer_pkg::*;
(
   input  logic             en,
   input  logic [BCD_W-1:0] m_hi_i,
   input  logic [BCD_W-1:0] m_lo_i,
   input  logic [BCD_W-1:0] s_hi_i,
   input  logic [BCD_W-1:0] s_lo_i,
   output logic [BCD_W-1:0] m_hi_o,
   output logic [BCD_W-1:0] m_lo_o,
   output logic [BCD_W-1:0] s_hi_o,
   output logic [BCD_W-1:0] s_lo_o,
   output logic             is_one,
   output logic             is_zero
);

   logic upper_zero;

   assign upper_zero = (m_hi_i == '0) && (m_lo_i == '0) && (s_hi_i == '0);
   assign is_zero    = upper_zero && (s_lo_i == '0);
   assign is_one     = upper_zero && (s_lo_i == BCD_W'(1));

   // Borrow ripples s_lo -> s_hi -> m_lo -> m_hi; the zero guard keeps
   // m_hi from wrapping below 0.
   always_comb begin
      m_hi_o = m_hi_i;
      m_lo_o = m_lo_i;
      s_hi_o = s_hi_i;
      s_lo_o = s_lo_i;
      if (en && !is_zero) begin
         if (s_lo_i != '0) begin
            s_lo_o = s_lo_i - BCD_W'(1);
         end else begin
            s_lo_o = BCD_W'(BCD_MAX);
            if (s_hi_i != '0) begin
               s_hi_o = s_hi_i - BCD_W'(1);
            end else begin
               s_hi_o = BCD_W'(SEC_TENS_MAX);
               if (m_lo_i != '0) begin
                  m_lo_o = m_lo_i - BCD_W'(1);
               end else begin
                  m_lo_o = BCD_W'(BCD_MAX);
                  m_hi_o = m_hi_i - BCD_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
// Runs an MM:SS setting (00:00..99:30) down to zero at 1 Hz and raises an
// alarm for ALARM_SEC seconds at expiry.
//   clk      : system clock (CLK_HZ)
//   reset_n  : asynchronous active-low reset
//   bus      : countdown_timer_if.slave (setting, pulses, digits, status)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | digits track the clamped setting, prescaler held at 0
// RUN   | prescaler counting, digits decrement once per second
// PAUSE | digits and prescaler frozen
// DONE  | digits 00:00, alarm high, counting seconds until auto-return
// ---------------------------------------------------------------------------
module countdown_timer
   import timer_pkg::*;
#(
   parameter int CLK_HZ    = 12000000,
   parameter int ALARM_SEC = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   countdown_timer_if.slave  bus
);

   localparam int              PS_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLK_HZ - 1);
   localparam logic [7:0]      ALM_LAST = 8'(ALARM_SEC - 1);

   state_t            state, state_nxt;
   logic [PS_W-1:0]   prescaler;
   logic [7:0]        alarm_cnt;
   logic              done_r;
   logic [BCD_W-1:0]  m_hi_r, m_lo_r, s_hi_r, s_lo_r;

   logic [BCD_W-1:0]  set_m_hi, set_m_lo, set_s_hi;
   logic              set_zero;
   logic              tick;

   logic [BCD_W-1:0]  dec_m_hi, dec_m_lo, dec_s_hi, dec_s_lo;
   logic              dec_one, dec_zero;

   logic              load_set, ps_clr, ps_run, dec_en;
   logic              alm_clr, alm_inc, done_nxt;

   assign set_m_hi = bcd_clamp(bus.set_hi);
   assign set_m_lo = bcd_clamp(bus.set_lo);
   assign set_s_hi = bus.set_half ? BCD_W'(HALF_TENS) : '0;
   assign set_zero = (set_m_hi == '0) && (set_m_lo == '0) && !bus.set_half;

   assign tick = (prescaler == PS_LAST);

   timer_bcd_dec u_dec (
      .en      (dec_en),
      .m_hi_i  (m_hi_r),
      .m_lo_i  (m_lo_r),
      .s_hi_i  (s_hi_r),
      .s_lo_i  (s_lo_r),
      .m_hi_o  (dec_m_hi),
      .m_lo_o  (dec_m_lo),
      .s_hi_o  (dec_s_hi),
      .s_lo_o  (dec_s_lo),
      .is_one  (dec_one),
      .is_zero (dec_zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_set  = 1'b0;
      ps_clr    = 1'b0;
      ps_run    = 1'b0;
      dec_en    = 1'b0;
      alm_clr   = 1'b0;
      alm_inc   = 1'b0;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            load_set = 1'b1;
            ps_clr   = 1'b1;
            if (bus.start_stop && !set_zero) state_nxt = RUN;
         end
         RUN: begin
            ps_run = 1'b1;
            dec_en = tick && !dec_zero;
            // Expiry wins over a simultaneous pause request.
            if (tick && dec_one) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
               alm_clr   = 1'b1;
            end else if (bus.start_stop) begin
               state_nxt = PAUSE;
            end
         end
         PAUSE: begin
            if (bus.start_stop) state_nxt = RUN;
         end
         DONE: begin
            ps_run = 1'b1;
            if (bus.start_stop) begin
               state_nxt = IDLE;
            end else if (tick) begin
               if (alarm_cnt == ALM_LAST) state_nxt = IDLE;
               else                       alm_inc   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (bus.cancel) begin
         state_nxt = IDLE;
         done_nxt  = 1'b0;
      end
      // Any path into IDLE picks up the setting and parks the prescaler.
      if (state_nxt == IDLE) begin
         load_set = 1'b1;
         ps_clr   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescaler <= '0;
         alarm_cnt <= '0;
         done_r    <= 1'b0;
         m_hi_r    <= '0;
         m_lo_r    <= '0;
         s_hi_r    <= '0;
         s_lo_r    <= '0;
      end else begin
         done_r <= done_nxt;

         if (ps_clr)      prescaler <= '0;
         else if (ps_run) prescaler <= tick ? '0 : prescaler + PS_W'(1);

         if (alm_clr)      alarm_cnt <= '0;
         else if (alm_inc) alarm_cnt <= alarm_cnt + 8'd1;

         if (load_set) begin
            m_hi_r <= set_m_hi;
            m_lo_r <= set_m_lo;
            s_hi_r <= set_s_hi;
            s_lo_r <= '0;
         end else if (dec_en) begin
            m_hi_r <= dec_m_hi;
            m_lo_r <= dec_m_lo;
            s_hi_r <= dec_s_hi;
            s_lo_r <= dec_s_lo;
         end
      end
   end

   assign bus.m_hi    = m_hi_r;
   assign bus.m_lo    = m_lo_r;
   assign bus.s_hi    = s_hi_r;
   assign bus.s_lo    = s_lo_r;
   assign bus.running = (state == RUN);
   assign bus.alarm   = (state == DONE);
   assign bus.done    = done_r;

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
// Directed scenarios followed by randomized pulses/settings, every cycle
// compared against a seconds-based reference model of the timer.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

   localparam int CLK_HZ    = 4;
   localparam int ALARM_SEC = 10;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   countdown_timer_if bus ();

   countdown_timer #(
      .CLK_HZ    (CLK_HZ),
      .ALARM_SEC (ALARM_SEC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // reference model: remaining time in seconds, position within the second
   int md;
   int rem;
   int phase;
   int alm_secs;
   int exp_done;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int set_secs();
      int h, l;
      h = (int'(bus.set_hi) > 9) ? 9 : int'(bus.set_hi);
      l = (int'(bus.set_lo) > 9) ? 9 : int'(bus.set_lo);
      return h * 600 + l * 60 + (bus.set_half ? 30 : 0);
   endfunction

   function automatic int to_bcd(input int secs);
      int mins, s;
      mins = secs / 60;
      s    = secs % 60;
      return ((mins / 10) << 12) | ((mins % 10) << 8) | ((s / 10) << 4) | (s % 10);
   endfunction

   function automatic int dut_digits();
      return int'({bus.m_hi, bus.m_lo, bus.s_hi, bus.s_lo});
   endfunction

   task automatic model_reset();
      md       = M_IDLE;
      rem      = 0;
      phase    = 0;
      alm_secs = 0;
      exp_done = 0;
   endtask

   // One clock edge of the timer, evaluated with the inputs seen before it.
   task automatic model_step(input bit ss, input bit cn);
      bit second_up;
      second_up = ((md == M_RUN) || (md == M_DONE)) && (phase == CLK_HZ - 1);
      exp_done  = 0;
      if (cn) begin
         md    = M_IDLE;
         rem   = set_secs();
         phase = 0;
      end else begin
         case (md)
            M_IDLE: begin
               rem   = set_secs();
               phase = 0;
               if (ss && rem != 0) md = M_RUN;
            end
            M_RUN: begin
               if (second_up) begin
                  phase = 0;
                  rem   = rem - 1;
                  if (rem == 0) begin
                     md       = M_DONE;
                     alm_secs = 0;
                     exp_done = 1;
                  end else if (ss) begin
                     md = M_PAUSE;
                  end
               end else begin
                  phase = phase + 1;
                  if (ss) md = M_PAUSE;
               end
            end
            M_PAUSE: begin
               if (ss) md = M_RUN;
            end
            default: begin
               if (second_up) begin
                  phase    = 0;
                  alm_secs = alm_secs + 1;
               end else begin
                  phase = phase + 1;
               end
               if (ss || alm_secs == ALARM_SEC) begin
                  md    = M_IDLE;
                  rem   = set_secs();
                  phase = 0;
               end
            end
         endcase
      end
   endtask

   task automatic check_all();
      check_val("digits",  dut_digits(),       to_bcd(rem));
      check_val("running", int'(bus.running),  (md == M_RUN)  ? 1 : 0);
      check_val("alarm",   int'(bus.alarm),    (md == M_DONE) ? 1 : 0);
      check_val("done",    int'(bus.done),     exp_done);
   endtask

   task automatic step(input bit ss, input bit cn);
      bus.start_stop = ss;
      bus.cancel     = cn;
      @(posedge clk);
      model_step(ss, cn);
      #1;
      bus.start_stop = 1'b0;
      bus.cancel     = 1'b0;
      check_all();
   endtask

   task automatic set_time(input int h, input int l, input bit half);
      bus.set_hi   = 4'(h);
      bus.set_lo   = 4'(l);
      bus.set_half = half;
   endtask

   task automatic run_until_rem(input int target, input int bound);
      for (int i = 0; i < bound && rem != target; i++) step(1'b0, 1'b0);
      check_val("reach_time", dut_digits(), to_bcd(target));
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.start_stop = 1'b0;
      bus.cancel     = 1'b0;
      set_time(0, 0, 1'b0);
      model_reset();
      #1;
      check_val("rst_digits",  dut_digits(),      0);
      check_val("rst_running", int'(bus.running), 0);
      check_val("rst_alarm",   int'(bus.alarm),   0);
      check_val("rst_done",    int'(bus.done),    0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // 01:30 start and first two seconds
      set_time(0, 1, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check_val("start_run", int'(bus.running), 1);
      check_val("start_0130", dut_digits(), 'h0130);
      repeat (4) step(1'b0, 1'b0);
      check_val("sec1_0129", dut_digits(), 'h0129);
      repeat (4) step(1'b0, 1'b0);
      check_val("sec2_0128", dut_digits(), 'h0128);

      // 00:00 start is ignored
      step(1'b0, 1'b1);
      set_time(0, 0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      check_val("zero_run", int'(bus.running), 0);
      check_val("zero_dig", dut_digits(), 'h0000);

      // 00:30 down to expiry, done pulse, alarm duration
      set_time(0, 0, 1'b1);
      step(1'b1, 1'b0);
      run_until_rem(1, 200);
      for (int i = 0; i < 16 && md != M_DONE; i++) step(1'b0, 1'b0);
      check_val("done_pulse", int'(bus.done),  1);
      check_val("done_alarm", int'(bus.alarm), 1);
      check_val("done_dig",   dut_digits(),    'h0000);
      step(1'b0, 1'b0);
      check_val("done_1cyc",  int'(bus.done),  0);
      repeat (ALARM_SEC * CLK_HZ - 2) step(1'b0, 1'b0);
      check_val("alarm_hold", int'(bus.alarm), 1);
      step(1'b0, 1'b0);
      check_val("alarm_end",  int'(bus.alarm), 0);

      // borrow chain
      set_time(1, 0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (CLK_HZ) step(1'b0, 1'b0);
      check_val("borrow_0959", dut_digits(), 'h0959);
      step(1'b0, 1'b1);
      set_time(0, 1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (CLK_HZ) step(1'b0, 1'b0);
      check_val("borrow_0059", dut_digits(), 'h0059);

      // pause at 00:45 with the prescaler part-way through a second
      run_until_rem(45, 100);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0);
      check_val("pause_dig", dut_digits(),      'h0045);
      check_val("pause_run", int'(bus.running), 0);
      step(1'b1, 1'b0);
      check_val("resume_run", int'(bus.running), 1);
      step(1'b0, 1'b0);
      check_val("resume_hold", dut_digits(), 'h0045);
      step(1'b0, 1'b0);
      check_val("resume_0044", dut_digits(), 'h0044);

      // cancel beats start_stop
      set_time(0, 2, 1'b1);
      step(1'b1, 1'b1);
      check_val("cancel_run", int'(bus.running), 0);
      step(1'b0, 1'b0);
      check_val("cancel_dig", dut_digits(), 'h0230);

      // asynchronous reset in the middle of RUN
      step(1'b1, 1'b0);
      repeat (6) step(1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("arst_digits",  dut_digits(),      0);
      check_val("arst_running", int'(bus.running), 0);
      check_val("arst_alarm",   int'(bus.alarm),   0);
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      reset_n = 1'b1;

      // randomized pulses and settings
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            set_time(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : 0,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                 : int'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
         end
         step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 399) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Consumes the minute/half-minute setting from the timer setup block (two BCD minute digits plus a 30-second flag) and runs it down to zero in real time. It drives MM:SS digits for the 7-segment display path and raises an alarm at expiry. One clock domain with an internal 1 Hz prescaler. Start/stop and cancel inputs are single-cycle pulses from the existing debouncers.

Parameters:
CLK_HZ, 12000000, system clock frequency; prescaler period in clocks (must be ≥2).
ALARM_SEC, 10, seconds the alarm stays asserted before auto-return to IDLE (1..255).

Ports:
clk  input  1  system clock, all logic on posedge.
reset_n  input  1  asynchronous, active-low reset.
set_hi  input  4  BCD tens of minutes from setup block.
set_lo  input  4  BCD units of minutes from setup block.
set_half  input  1  adds 30 s to the setting.
start_stop  input  1  one-cycle pulse: start / pause / resume / acknowledge.
cancel  input  1  one-cycle pulse: abort to IDLE.
m_hi, m_lo, s_hi, s_lo  output  4 each  displayed BCD digits MM:SS.
running  output  1  high in RUN.
alarm  output  1  high in DONE.
done  output  1  one-cycle pulse on the cycle DONE is entered.

Behaviour:
- Reset (async, reset_n=0): state IDLE, all digits 0, prescaler 0, alarm/running/done 0, alarm counter 0.
- Setting inputs: set_hi/set_lo values >9 are clamped to 9. set_half maps to s_hi=3, s_lo=0; otherwise both are 0.
- IDLE: registered digits track the clamped setting every cycle (one-cycle latency).
  - start_stop with setting ≠ 00:00 → load digits, prescaler←0, go RUN.
  - start_stop with setting = 00:00 → ignored.
- RUN: prescaler counts 0..CLK_HZ-1. tick = prescaler==CLK_HZ-1; prescaler wraps to 0 on tick.
  - On tick, the BCD borrow chain decrements: s_lo 0→9 borrows s_hi; s_hi 0→5 borrows m_lo; m_lo 0→9 borrows m_hi.
  - Tick when the value is 00:01 → digits 00:00, go DONE, done=1 for that cycle.
  - start_stop → PAUSE. If a tick lands in the same cycle, the decrement still applies.
- PAUSE: digits and prescaler hold. start_stop → RUN; the prescaler resumes from its held value.
- DONE: alarm=1, digits 00:00. The prescaler keeps running; the alarm counter increments per tick.
  - After ALARM_SEC ticks → IDLE.
  - start_stop in DONE → IDLE next cycle.
- cancel: any state → IDLE next cycle; alarm and running drop. cancel beats start_stop in the same cycle.
- Setting inputs are ignored outside IDLE. Digits never leave valid BCD; 00:00 is never decremented.
- Max value 99:30 (5970 s). Prescaler width is clog2(CLK_HZ). Alarm counter is 8 bits.
- Outputs running and alarm are decoded from registered state (no glitches). done is registered.

Decomposition:
- Package timer_pkg: state enum (IDLE, RUN, PAUSE, DONE), BCD_W=4, constants BCD_MAX=9, SEC_TENS_MAX=5, HALF_TENS=3.
- One sub-module, timer_bcd_dec, is natural. Combinational 4-digit MM:SS decrement with zero flag: inputs are four digits plus enable; outputs are the next four digits and is_one/is_zero. It is shared with any future count-up stopwatch.

Test Plan:
- CLK_HZ=4. Reset release, set 01 min + half, start_stop → digits 01:30, running=1; after 4 clocks 01:29; after 8 clocks 01:28.
- Setting 00:00 + half=0, start_stop → stays IDLE, running=0, digits 00:00.
- Load 00:01 (forced via 00 + half, then let it run to 00:01) → tick → 00:00, done pulse exactly 1 cycle, alarm=1. After ALARM_SEC·4 clocks → IDLE, alarm=0.
- Borrow chain: RUN at 10:00, one tick → 09:59. At 01:00 → 00:59.
- Pause at 00:45 mid-prescaler (count=2), wait 20 clocks → digits unchanged. start_stop → next tick after 2 more clocks → 00:44.
- cancel and start_stop in the same cycle during RUN → IDLE, digits follow setting. reset_n pulsed low mid-RUN → immediate all-zero outputs, IDLE.
